// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: drives the select (A) and enable (E) inputs of a 3x8 decoder so that
// its D output is scanned one-hot, slot by slot.
// Latency: start/stop act at the next rising edge; every output is a flop, with no input-to-output path.
// Backpressure: none. start is sampled only in IDLE, and stop aborts from any state.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  synchronous active-low reset, priority over all other inputs
//   i_start  level-sampled scan request, accepted only in IDLE
//   i_stop   abort request, honoured in any state, wins over start and over a slot advance
//   i_mode   0 = single sweep, 1 = continuous; captured when start is accepted
//   o_a      decoder select (3 bits)
//   o_e      decoder enable
//   o_busy   high while scanning
//   o_done   one-cycle pulse on normal completion of a single sweep

module decoder_scan_sequencer #(
   parameter int PRESCALE = 4,   // cycles per slot, 1..255
   parameter int N_SLOTS  = 8    // slots per sweep, 1..8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_stop,
   input  logic       i_mode,
   output logic [2:0] o_a,
   output logic       o_e,
   output logic       o_busy,
   output logic       o_done
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   // Terminal values. They are fixed-width constants so the compares below are width-exact.
   localparam logic [7:0] LP_CNT_LAST  = 8'(PRESCALE - 1);
   localparam logic [2:0] LP_SLOT_LAST = 3'(N_SLOTS - 1);

   logic [0:0] r_state;
   logic [7:0] r_cnt;
   logic [2:0] r_a;
   logic       r_e;
   logic       r_busy;
   logic       r_done;
   logic       r_mode;

   logic       w_slot_end;    // the current slot has held for PRESCALE cycles
   logic       w_last_slot;   // A is the final slot of the sweep

   assign w_slot_end  = (r_cnt == LP_CNT_LAST);
   assign w_last_slot = (r_a == LP_SLOT_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
         r_a     <= 3'd0;
         r_e     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_mode  <= 1'b0;
      end else begin
         // done is a single-cycle pulse. Only the final advance of a single sweep sets it.
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cnt  <= 8'd0;
               r_a    <= 3'd0;
               r_e    <= 1'b0;
               r_busy <= 1'b0;
               // stop wins over a simultaneous start
               if (i_start && !i_stop) begin
                  r_state <= ST_SCAN;
                  r_e     <= 1'b1;
                  r_busy  <= 1'b1;
                  r_mode  <= i_mode;
               end
            end
            ST_SCAN: begin
               // start and mode are deliberately ignored here. The count keeps running undisturbed.
               if (i_stop) begin
                  // abort beats any slot advance at this same edge
                  r_state <= ST_IDLE;
                  r_cnt   <= 8'd0;
                  r_a     <= 3'd0;
                  r_e     <= 1'b0;
                  r_busy  <= 1'b0;
               end else if (w_slot_end) begin
                  r_cnt <= 8'd0;
                  if (!w_last_slot) begin
                     r_a <= r_a + 3'd1;
                  end else if (r_mode) begin
                     // continuous: wrap with E held high, so no gap appears between sweeps
                     r_a <= 3'd0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_a     <= 3'd0;
                     r_e     <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= 8'd0;
               r_a     <= 3'd0;
               r_e     <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_a    = r_a;
   assign o_e    = r_e;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer. It drives a default instance (4/8) and a corner instance (1/3).
// Each stimulus cycle pushes the outputs expected after the next edge. A monitor pops them on
// the falling edge and compares.

module tb_decoder_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s0_start, s0_stop, s0_mode;
   logic       s1_start, s1_stop, s1_mode;
   logic [2:0] d0_a, d1_a;
   logic       d0_e, d0_busy, d0_done;
   logic       d1_e, d1_busy, d1_done;

   int tests = 0;
   int fails = 0;
   int phase = 0;

   typedef struct {
      int         inst;
      logic       chk;
      logic [2:0] a;
      logic       e;
      logic       busy;
      logic       done;
      int         ph;
   } exp_t;

   exp_t exp_q[$];

   decoder_scan_sequencer #(.PRESCALE(4), .N_SLOTS(8)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(s0_start), .i_stop(s0_stop), .i_mode(s0_mode),
      .o_a(d0_a), .o_e(d0_e), .o_busy(d0_busy), .o_done(d0_done)
   );

   decoder_scan_sequencer #(.PRESCALE(1), .N_SLOTS(3)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(s1_start), .i_stop(s1_stop), .i_mode(s1_mode),
      .o_a(d1_a), .o_e(d1_e), .o_busy(d1_busy), .o_done(d1_done)
   );

   initial forever #5 clk = ~clk;

   // Drive the inputs that the coming rising edge will see, and queue the outputs
   // expected after that edge. Then advance past the edge.
   task automatic step(input int inst, input logic rst, input logic st, input logic sp,
                       input logic md, input logic chk, input logic [2:0] a,
                       input logic e, input logic b, input logic d);
      exp_t x;
      rst_n = rst;
      if (inst == 0) begin
         s0_start = st; s0_stop = sp; s0_mode = md;
         s1_start = 1'b0; s1_stop = 1'b0; s1_mode = 1'b0;
      end else begin
         s1_start = st; s1_stop = sp; s1_mode = md;
         s0_start = 1'b0; s0_stop = 1'b0; s0_mode = 1'b0;
      end
      x.inst = inst; x.chk = chk; x.a = a; x.e = e; x.busy = b; x.done = d; x.ph = phase;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t       x;
      logic [2:0] ga;
      logic       ge, gb, gd;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         if (x.chk) begin
            if (x.inst == 0) begin
               ga = d0_a; ge = d0_e; gb = d0_busy; gd = d0_done;
            end else begin
               ga = d1_a; ge = d1_e; gb = d1_busy; gd = d1_done;
            end
            tests++;
            if (ga !== x.a || ge !== x.e || gb !== x.busy || gd !== x.done) begin
               fails++;
               $display("FAIL outputs phase=%0d inst=%0d t=%0t got a=%0d e=%b busy=%b done=%b required a=%0d e=%b busy=%b done=%b",
                        x.ph, x.inst, $time, ga, ge, gb, gd, x.a, x.e, x.busy, x.done);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      s0_start = 1'b0; s0_stop = 1'b0; s0_mode = 1'b0;
      s1_start = 1'b0; s1_stop = 1'b0; s1_mode = 1'b0;

      // Phase 1: reset for 2 cycles. Start is held high to confirm reset has priority.
      phase = 1;
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

      // Phase 2: single sweep. A=0..7 with 4 cycles each, then a done pulse, then idle.
      phase = 2;
      for (int i = 0; i < 32; i++)
         step(0, 1'b1, (i == 0), 1'b0, 1'b0, 1'b1, 3'(i / 4), 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

      // Phase 3: continuous for 80 cycles. A wraps 7->0 with no done, then stop.
      phase = 3;
      for (int i = 0; i < 80; i++)
         step(0, 1'b1, (i == 0), 1'b0, (i == 0), 1'b1, 3'((i / 4) % 8), 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

      // Phase 4: stop on the edge where A=2 and count=3 would advance. The result must be A=0, not 3.
      phase = 4;
      for (int i = 0; i < 12; i++)
         step(0, 1'b1, (i == 0), 1'b0, 1'b0, 1'b1, 3'(i / 4), 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

      // Phase 5: start and stop together in IDLE. The block stays idle.
      phase = 5;
      step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

      // Phase 6: start pulsed at A=4 does not restart the sweep. A reaches 5 on schedule.
      phase = 6;
      for (int i = 0; i < 32; i++)
         step(0, 1'b1, (i == 0 || i == 17), 1'b0, 1'b0, 1'b1, 3'(i / 4), 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

      // Phase 7: mode raised mid-sweep. The sweep still ends with done after A=7.
      phase = 7;
      for (int i = 0; i < 32; i++)
         step(0, 1'b1, (i == 0), 1'b0, (i >= 5), 1'b1, 3'(i / 4), 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

      // Phase 8: start held through completion. There is exactly one idle (done) cycle, then a new sweep.
      phase = 8;
      for (int i = 0; i < 32; i++)
         step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'(i / 4), 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

      // Phase 9: synchronous reset while A=5. Outputs hold until the edge, then clear with no done.
      phase = 9;
      for (int i = 0; i < 21; i++)
         step(0, 1'b1, (i == 0), 1'b0, 1'b0, 1'b1, 3'(i / 4), 1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      #2;
      tests++;
      if (d0_a !== 3'd5 || d0_e !== 1'b1 || d0_busy !== 1'b1) begin
         fails++;
         $display("FAIL sync_reset_hold got a=%0d e=%b busy=%b required a=5 e=1 busy=1",
                  d0_a, d0_e, d0_busy);
      end
      step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

      // Phase 10: PRESCALE=1, N_SLOTS=3. A=0,1,2 on consecutive cycles, then done.
      phase = 10;
      step(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
      step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
      step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
      step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
      step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

      // Drain the scoreboard. The wait is bounded.
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Synchronous upstream driver for the 3x8 decoder stage: generates the 3-bit select A and enable E.
- Steps A through slots 0..N_SLOTS-1. Each slot holds for PRESCALE clock cycles.
- Runs as a single sweep or continuously, under start/stop control.
- Its outputs connect directly to the decoder's A and E inputs, so the decoder's D output is one-hot scanned.

Parameters:
- PRESCALE, 4, clock cycles each slot is held with E=1; legal range 1..255.
- N_SLOTS, 8, number of slots scanned (A = 0..N_SLOTS-1); legal range 1..8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  level-sampled request to begin a scan; honoured only in IDLE.
- stop  input  1  abort request; honoured in any state.
- mode  input  1  0 = single sweep, 1 = continuous; latched when start is accepted.
- A  output  3  decoder select, registered.
- E  output  1  decoder enable, registered.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse on normal completion of a single sweep.

Behaviour:
- Reset: rst_n=0 at a rising edge gives A=3'b000, E=0, busy=0, done=0, prescale count=0, latched mode=0, state=IDLE.
  - Reset has priority over every other input.
  - Reset asserted mid-scan aborts immediately, with no done pulse.
- All outputs are registered; there is no combinational path from any input to any output.
- States: IDLE, SCAN.
- IDLE:
  - Outputs: A=0, E=0, busy=0.
  - start=1 and stop=0 at edge t: from t onward state=SCAN, A=0, E=1, busy=1, prescale count=0, latched mode=mode.
  - start=1 and stop=1 together: stop wins; the block stays in IDLE.
- SCAN:
  - The prescale count increments each cycle.
  - When the count equals PRESCALE-1, the count wraps to 0 and the slot advances at that edge.
  - Advance with A < N_SLOTS-1: A = A+1, E stays 1.
  - Advance with A = N_SLOTS-1 and latched mode=1: A wraps to 0, E stays 1, no done pulse.
  - Advance with A = N_SLOTS-1 and latched mode=0: state=IDLE, A=0, E=0, busy=0, done=1 for exactly one cycle.
- Slot timing:
  - Each slot holds E=1 with a stable A for exactly PRESCALE cycles.
  - A changes only at slot boundaries; E never glitches low between slots.
  - A single sweep keeps E high for exactly N_SLOTS*PRESCALE cycles.
- stop=1 in SCAN: at the next edge state=IDLE, A=0, E=0, busy=0, no done pulse.
  - stop has priority over a simultaneous slot advance or wrap.
- start while in SCAN: ignored; no restart, and the prescale count is not disturbed.
- mode changes while in SCAN: ignored until the next accepted start.
- Restart: start held high through completion re-triggers.
  - The done cycle is in IDLE, so the next edge with start=1 begins a new sweep.
  - That gives exactly one IDLE cycle between sweeps.
- PRESCALE=1: A advances every cycle.
- N_SLOTS=1: A stays 0 throughout the scan.
- The A register never holds a value >= N_SLOTS.

Test Plan:
- Reset, then single sweep: rst_n=0 for 2 cycles, then release; pulse start for 1 cycle with mode=0 (defaults 4/8).
  - A=0..7, each held 4 cycles, with E=1 for 32 cycles.
  - Then E=0, A=0, busy=0, and done=1 for exactly 1 cycle.
- Continuous wrap: start with mode=1 and run 80 cycles.
  - A sequence ...6,7,0,1... with E continuously 1 and done never asserted.
  - Then stop=1 gives E=0, A=0, busy=0 at the next edge, no done.
- Stop coinciding with a slot boundary: assert stop on the cycle where the prescale count=3 and A=2.
  - Next edge: IDLE, A=0 (not 3), E=0, no done.
- Simultaneous start+stop in IDLE stays in IDLE (E=0, busy=0).
- Start pulsed during SCAN at A=4 does not restart: A continues to 5 on schedule.
- Mode toggled mid-sweep from 0 to 1 still ends with done after A=7.
- Synchronous reset mid-scan: rst_n=0 while A=5, E=1.
  - Next edge: A=0, E=0, busy=0, done=0.
  - Output does not change before the clock edge (verifies synchronous reset).
- Parameter corner, PRESCALE=1, N_SLOTS=3, mode=0:
  - A = 0,1,2 on consecutive cycles, E high for 3 cycles.
  - done on the 4th cycle after the start edge.
